// File: rtl/hash_lookup_ctrl_pkg.sv
// Shared definitions for the hash lookup controller.
// Holds the bucket entry layout (valid bit, stored key, stored data),
// bus widths and the controller state type.
package hash_lookup_ctrl_pkg;

  localparam int unsigned QUAD_W = 64;  // key width
  localparam int unsigned DATA_W = 32;  // hash and data word width

  // Bucket entry: {valid, key[63:0], data[31:0]}
  localparam int unsigned ENTRY_W         = 97;
  localparam int unsigned ENTRY_VALID_BIT = 96;
  localparam int unsigned ENTRY_KEY_MSB   = 95;
  localparam int unsigned ENTRY_KEY_LSB   = 32;
  localparam int unsigned ENTRY_DATA_MSB  = 31;
  localparam int unsigned ENTRY_DATA_LSB  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StHash,
    StRead,
    StCmp,
    StResp
  } lookup_state_t;

endpackage

// File: rtl/hash_lookup_ctrl.sv
// Hash lookup controller: accepts one key lookup at a time, drives the hash
// engine, reads the bucket selected by the low hash bits, compares the stored
// key and returns hit/miss, the stored data and the hash used.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_*               lookup request handshake and key
//   hash_start_o/key_o  hash engine request (held until the result arrives)
//   hash_ready_i/val_i  hash engine result
//   tbl_rd_*            synchronous bucket table read (data one cycle later)
//   resp_*              response handshake: hit, timeout error, data, hash
module hash_lookup_ctrl
  import hash_lookup_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W        = 10,
  parameter int unsigned HASH_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [QUAD_W-1:0]  req_key_i,
  output logic               hash_start_o,
  output logic [QUAD_W-1:0]  hash_key_o,
  input  logic               hash_ready_i,
  input  logic [DATA_W-1:0]  hash_val_i,
  output logic               tbl_rd_en_o,
  output logic [IDX_W-1:0]   tbl_rd_addr_o,
  input  logic [ENTRY_W-1:0] tbl_rd_data_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic               resp_hit_o,
  output logic               resp_err_o,
  output logic [DATA_W-1:0]  resp_data_o,
  output logic [DATA_W-1:0]  resp_hash_o
);

  // One spare bit so the final increment on leaving HASH cannot wrap.
  localparam int unsigned       TimerW    = $clog2(HASH_TIMEOUT) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(HASH_TIMEOUT - 1);

  lookup_state_t     state_q;
  logic [QUAD_W-1:0] key_q;
  logic [DATA_W-1:0] hash_q;
  logic [TimerW-1:0] timer_q;
  logic              req_ready_q;
  logic              hash_start_q;
  logic              tbl_rd_en_q;
  logic [IDX_W-1:0]  tbl_rd_addr_q;
  logic              resp_valid_q;
  logic              resp_hit_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_data_q;
  logic [DATA_W-1:0] resp_hash_q;

  logic entry_hit;
  assign entry_hit = tbl_rd_data_i[ENTRY_VALID_BIT] &&
                     (tbl_rd_data_i[ENTRY_KEY_MSB:ENTRY_KEY_LSB] == key_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      key_q         <= '0;
      hash_q        <= '0;
      timer_q       <= '0;
      req_ready_q   <= 1'b0;
      hash_start_q  <= 1'b0;
      tbl_rd_en_q   <= 1'b0;
      tbl_rd_addr_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
      resp_hash_q   <= '0;
    end else begin
      tbl_rd_en_q <= 1'b0;  // single-cycle strobe
      unique case (state_q)
        StIdle: begin
          // Ready rises on the first edge out of reset and stays up while idle.
          req_ready_q <= 1'b1;
          resp_hit_q  <= 1'b0;
          resp_err_q  <= 1'b0;
          resp_data_q <= '0;
          resp_hash_q <= '0;
          if (req_valid_i && req_ready_q) begin
            key_q        <= req_key_i;
            timer_q      <= '0;
            req_ready_q  <= 1'b0;
            hash_start_q <= 1'b1;
            state_q      <= StHash;
          end
        end
        StHash: begin
          timer_q <= timer_q + TimerW'(1);
          // A result on the last allowed cycle still wins over the timeout.
          if (hash_ready_i) begin
            hash_q        <= hash_val_i;
            tbl_rd_en_q   <= 1'b1;
            tbl_rd_addr_q <= hash_val_i[IDX_W-1:0];
            hash_start_q  <= 1'b0;
            state_q       <= StRead;
          end else if (timer_q == TimerLast) begin
            hash_start_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            resp_err_q   <= 1'b1;
            resp_data_q  <= '0;
            resp_hash_q  <= '0;
            state_q      <= StResp;
          end
        end
        StRead: begin
          state_q <= StCmp;
        end
        StCmp: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= entry_hit;
          resp_err_q   <= 1'b0;
          resp_data_q  <= entry_hit ? tbl_rd_data_i[ENTRY_DATA_MSB:ENTRY_DATA_LSB] : '0;
          resp_hash_q  <= hash_q;
          state_q      <= StResp;
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign hash_start_o  = hash_start_q;
  assign hash_key_o    = key_q;
  assign tbl_rd_en_o   = tbl_rd_en_q;
  assign tbl_rd_addr_o = tbl_rd_addr_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_hit_o    = resp_hit_q;
  assign resp_err_o    = resp_err_q;
  assign resp_data_o   = resp_data_q;
  assign resp_hash_o   = resp_hash_q;

endmodule

// File: tb/tb_hash_lookup_ctrl.sv
// Self-checking bench for hash_lookup_ctrl: behavioural hash engine and
// synchronous table, a transaction-level reference model checked every cycle,
// directed literal cases and a randomized lookup phase.
module tb_hash_lookup_ctrl;

  localparam int unsigned IDX_W = 4;
  localparam int          T     = 8;
  localparam int          DEPTH = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [63:0]       req_key_i = '0;
  logic              hash_start_o;
  logic [63:0]       hash_key_o;
  logic              hash_ready_i = 1'b0;
  logic [31:0]       hash_val_i = '0;
  logic              tbl_rd_en_o;
  logic [IDX_W-1:0]  tbl_rd_addr_o;
  logic [96:0]       tbl_rd_data_i = '0;
  logic              resp_valid_o;
  logic              resp_ready_i = 1'b0;
  logic              resp_hit_o;
  logic              resp_err_o;
  logic [31:0]       resp_data_o;
  logic [31:0]       resp_hash_o;

  logic [96:0] mem [DEPTH];
  int          eng_lat = 1;
  bit          eng_stub = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  hash_lookup_ctrl #(
    .IDX_W       (IDX_W),
    .HASH_TIMEOUT(T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_key_i    (req_key_i),
    .hash_start_o (hash_start_o),
    .hash_key_o   (hash_key_o),
    .hash_ready_i (hash_ready_i),
    .hash_val_i   (hash_val_i),
    .tbl_rd_en_o  (tbl_rd_en_o),
    .tbl_rd_addr_o(tbl_rd_addr_o),
    .tbl_rd_data_i(tbl_rd_data_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_hit_o   (resp_hit_o),
    .resp_err_o   (resp_err_o),
    .resp_data_o  (resp_data_o),
    .resp_hash_o  (resp_hash_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hash_fn(input logic [63:0] k);
    return k[63:32] ^ k[31:0] ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expire(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired, got no event, expected one (cycle %0d)", name, cyc);
  endtask

  // Hash engine and table responder, driven on the falling edge.
  initial begin
    int   eng_cnt;
    bit   eng_done;
    bit   ram_pend;
    logic [IDX_W-1:0] ram_addr;
    eng_cnt  = 0;
    eng_done = 1'b0;
    ram_pend = 1'b0;
    ram_addr = '0;
    forever begin
      @(negedge clk);
      // Table data appears one cycle after the strobe; garbage otherwise.
      if (ram_pend) tbl_rd_data_i = mem[ram_addr];
      else tbl_rd_data_i = {1'($urandom), $urandom, $urandom, $urandom};
      ram_pend = tbl_rd_en_o;
      ram_addr = tbl_rd_addr_o;
      hash_ready_i = 1'b0;
      if (hash_start_o) begin
        if (!eng_done) begin
          eng_cnt++;
          if (!eng_stub && eng_cnt == eng_lat) begin
            hash_ready_i = 1'b1;
            hash_val_i   = hash_fn(hash_key_o);
            eng_done     = 1'b1;
          end else begin
            hash_val_i = $urandom;
          end
        end
      end else begin
        eng_cnt  = 0;
        eng_done = 1'b0;
        // Stray results outside a hash phase must be ignored.
        hash_ready_i = ($urandom_range(0, 3) == 0);
        hash_val_i   = $urandom;
      end
    end
  end

  // Reference model and per-cycle compare.
  initial begin
    bit               m_busy, m_ok, m_rst_prev;
    int               m_exit, m_resp, m_clear, a;
    logic [63:0]      m_key;
    logic             m_hit, m_err;
    logic [31:0]      m_data, m_hash, h;
    logic [IDX_W-1:0] m_idx;
    logic [96:0]      e;
    m_busy = 1'b0; m_ok = 1'b0; m_rst_prev = 1'b0;
    m_exit = 0; m_resp = 0; m_clear = 0;
    m_key = '0; m_hit = 1'b0; m_err = 1'b0; m_data = '0; m_hash = '0; m_idx = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
        chk("rst_ctrl", 64'({req_ready_o, hash_start_o, tbl_rd_en_o, resp_valid_o,
                             resp_hit_o, resp_err_o}), '0);
        chk("rst_key", hash_key_o, '0);
        chk("rst_resp_words", {resp_data_o, resp_hash_o}, '0);
        m_busy = 1'b0; m_rst_prev = 1'b1; m_key = '0; m_clear = 0;
      end else if (m_rst_prev) begin
        chk("post_rst_ready", 64'(req_ready_o), '0);
        chk("post_rst_valid", 64'(resp_valid_o), '0);
        m_rst_prev = 1'b0;
      end else if (!m_busy) begin
        chk("idle_ready", 64'(req_ready_o), 64'd1);
        chk("idle_start", 64'(hash_start_o), '0);
        chk("idle_rd_en", 64'(tbl_rd_en_o), '0);
        chk("idle_valid", 64'(resp_valid_o), '0);
        chk("idle_key", hash_key_o, m_key);
        if (cyc >= m_clear)
          chk("idle_resp_clear", {30'd0, resp_hit_o, resp_err_o, resp_data_o}, '0);
        if (cyc >= m_clear) chk("idle_hash_clear", 64'(resp_hash_o), '0);
        if (req_valid_i) begin
          a      = cyc + 1;
          m_busy = 1'b1;
          m_key  = req_key_i;
          m_ok   = !eng_stub && (eng_lat <= T);
          h      = hash_fn(m_key);
          m_idx  = h[IDX_W-1:0];
          e      = mem[m_idx];
          if (m_ok) begin
            m_err  = 1'b0;
            m_hit  = e[96] && (e[95:32] == m_key);
            m_data = m_hit ? e[31:0] : 32'd0;
            m_hash = h;
            m_exit = a + eng_lat;
            m_resp = a + eng_lat + 2;
          end else begin
            m_err  = 1'b1;
            m_hit  = 1'b0;
            m_data = '0;
            m_hash = '0;
            m_exit = a + T;
            m_resp = a + T;
          end
        end
      end else begin
        chk("busy_ready", 64'(req_ready_o), '0);
        chk("busy_key", hash_key_o, m_key);
        chk("busy_start", 64'(hash_start_o), 64'(cyc < m_exit));
        chk("busy_rd_en", 64'(tbl_rd_en_o), 64'(m_ok && cyc == m_exit));
        if (m_ok && cyc == m_exit) chk("rd_addr", 64'(tbl_rd_addr_o), 64'(m_idx));
        chk("busy_valid", 64'(resp_valid_o), 64'(cyc >= m_resp));
        if (cyc >= m_resp) begin
          chk("resp_hit", 64'(resp_hit_o), 64'(m_hit));
          chk("resp_err", 64'(resp_err_o), 64'(m_err));
          chk("resp_data", 64'(resp_data_o), 64'(m_data));
          chk("resp_hash", 64'(resp_hash_o), 64'(m_hash));
          if (resp_ready_i) begin
            m_busy  = 1'b0;
            m_clear = cyc + 2;
          end
        end
      end
    end
  end

  // One lookup; called and returns on a falling edge with the controller idle.
  task automatic do_req(input logic [63:0] key, input int lat, input bit stub, input int dly,
                        output logic hit, output logic err, output logic [31:0] data,
                        output logic [31:0] hash);
    int n;
    hit = 1'b0; err = 1'b0; data = '0; hash = '0;
    eng_lat      = lat;
    eng_stub     = stub;
    resp_ready_i = (dly == 0);
    req_key_i    = key;
    req_valid_i  = 1'b1;
    n = 0;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      expire("req_accept");
      req_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    req_key_i   = {$urandom, $urandom};
    n = 0;
    while (!resp_valid_o && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      expire("resp_valid");
      return;
    end
    if (dly > 0) begin
      repeat (dly) @(negedge clk);
      resp_ready_i = 1'b1;
    end
    hit  = resp_hit_o;
    err  = resp_err_o;
    data = resp_data_o;
    hash = resp_hash_o;
    @(negedge clk);
    resp_ready_i = 1'b0;
  endtask

  initial begin
    logic [63:0]      k1, k2, k3, key;
    logic [63:0]      pool [8];
    logic             r_hit, r_err;
    logic [31:0]      r_data, r_hash, h;
    int               n;
    k1 = 64'hdead_beef_abcd_ef00;  // hash 6754_0797, slot 7
    k2 = 64'hdead_beef_abcd_ef01;  // hash 6754_0796, slot 6
    k3 = 64'hdead_beef_abcd_ef10;  // hash 6754_0787, slot 7
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[7] = {1'b1, k1, 32'hcafe_f00d};
    mem[6] = {1'b0, k2, 32'h1111_2222};

    #1 rst = 1'b1;
    #2;
    chk("reset_req_ready", 64'(req_ready_o), '0);
    chk("reset_resp_valid", 64'(resp_valid_o), '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Hit
    do_req(k1, 3, 1'b0, 0, r_hit, r_err, r_data, r_hash);
    chk("t1_hit", 64'(r_hit), 64'd1);
    chk("t1_data", 64'(r_data), 64'hcafe_f00d);
    chk("t1_hash", 64'(r_hash), 64'h6754_0797);
    chk("t1_err", 64'(r_err), '0);

    // Miss: same slot, different key; then valid bit clear with matching key
    do_req(k3, 2, 1'b0, 0, r_hit, r_err, r_data, r_hash);
    chk("t2_hit", 64'(r_hit), '0);
    chk("t2_data", 64'(r_data), '0);
    chk("t2_hash", 64'(r_hash), 64'h6754_0787);
    do_req(k2, 1, 1'b0, 0, r_hit, r_err, r_data, r_hash);
    chk("t2_invalid_hit", 64'(r_hit), '0);
    chk("t2_invalid_data", 64'(r_data), '0);

    // Backpressure
    do_req(k1, 4, 1'b0, 10, r_hit, r_err, r_data, r_hash);
    chk("t3_hit", 64'(r_hit), 64'd1);
    chk("t3_data", 64'(r_data), 64'hcafe_f00d);

    // Timeout, result on the last allowed cycle, result one cycle too late
    do_req(k1, 1, 1'b1, 0, r_hit, r_err, r_data, r_hash);
    chk("t4_err", 64'(r_err), 64'd1);
    chk("t4_hash", 64'(r_hash), '0);
    chk("t4_hit_data", {31'd0, r_hit, r_data}, '0);
    do_req(k1, T, 1'b0, 0, r_hit, r_err, r_data, r_hash);
    chk("t4_edge_err", 64'(r_err), '0);
    chk("t4_edge_hit", 64'(r_hit), 64'd1);
    do_req(k1, T + 1, 1'b0, 2, r_hit, r_err, r_data, r_hash);
    chk("t4_late_err", 64'(r_err), 64'd1);

    // Reset during the table read
    eng_lat = 3; eng_stub = 1'b0; resp_ready_i = 1'b1;
    req_key_i = k1; req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    n = 0;
    while (!tbl_rd_en_o && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) expire("t5_read");
    chk("t5_rd_addr", 64'(tbl_rd_addr_o), 64'd7);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_rd_en", 64'(tbl_rd_en_o), '0);
    chk("t5_async_key", hash_key_o, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_ready_i = 1'b0;
    repeat (10) @(negedge clk);
    do_req(k1, 2, 1'b0, 0, r_hit, r_err, r_data, r_hash);
    chk("t5_after_hit", 64'(r_hit), 64'd1);
    chk("t5_after_data", 64'(r_data), 64'hcafe_f00d);

    // Back-to-back
    do_req(k1, 2, 1'b0, 0, r_hit, r_err, r_data, r_hash);
    chk("t6_first_hit", 64'(r_hit), 64'd1);
    do_req(k3, 5, 1'b0, 0, r_hit, r_err, r_data, r_hash);
    chk("t6_second_hash", 64'(r_hash), 64'h6754_0787);

    // Randomized lookups over a table seeded with a small key pool
    for (int i = 0; i < 8; i++) pool[i] = {$urandom, $urandom};
    for (int i = 0; i < DEPTH; i++) mem[i] = {1'($urandom), $urandom, $urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      h = hash_fn(pool[i]);
      mem[h[IDX_W-1:0]] = {($urandom_range(0, 4) != 0), pool[i], $urandom};
    end
    repeat (150) begin
      key = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 7)] : {$urandom, $urandom};
      do_req(key, $urandom_range(1, T + 2), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
             r_hit, r_err, r_data, r_hash);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
